// File: rtl/tile_collider_if.sv
// Move request, map probe port and committed-position outputs of the tile collider.
// The collider takes the slave view; the game/map side takes the master view.
interface tile_collider_if;
   logic              start;
   logic signed [5:0] dx;
   logic signed [5:0] dy;
   logic [9:0]        probe_x;
   logic [9:0]        probe_y;
   logic              probe_hit;
   logic [9:0]        pos_x;
   logic [9:0]        pos_y;
   logic              busy;
   logic              done;
   logic              grounded;
   logic              hit_wall;
   logic              hit_ceiling;

   modport master (
      output start, dx, dy, probe_hit,
      input  probe_x, probe_y, pos_x, pos_y, busy, done, grounded, hit_wall, hit_ceiling
   );

   modport slave (
      input  start, dx, dy, probe_hit,
      output probe_x, probe_y, pos_x, pos_y, busy, done, grounded, hit_wall, hit_ceiling
   );
endinterface

// File: rtl/tile_collider.sv
// Per-frame movement resolver: probes the four box corners against the tile map,
// X axis first then Y, and commits an axis-separated collision-free position.
module tile_collider #(
   parameter int X_INIT = 175,
   parameter int Y_INIT = 66,
   parameter int W      = 32,
   parameter int H      = 32
) (
   input logic           clk,
   input logic           rst_n,
   tile_collider_if.slave bus
);

   localparam logic [9:0] W_OFF = 10'(W - 1);
   localparam logic [9:0] H_OFF = 10'(H - 1);

   typedef enum logic [2:0] {IDLE, PX, CX, PY, CY} state_t;

   state_t            state;
   logic [1:0]        k;
   logic signed [5:0] dx_q;
   logic signed [5:0] dy_q;
   logic [10:0]       cand_x;
   logic [10:0]       cand_y;
   logic [9:0]        x_res;
   logic [9:0]        pos_x_q;
   logic [9:0]        pos_y_q;
   logic [9:0]        probe_x_q;
   logic [9:0]        probe_y_q;
   logic              blocked;
   logic              hit_wall_n;
   logic              busy_q;
   logic              done_q;
   logic              grounded_q;
   logic              hit_wall_q;
   logic              hit_ceiling_q;

   logic [10:0]       start_cand_x;
   logic [10:0]       next_cand_y;
   logic [1:0]        next_k;
   logic [9:0]        base_x;
   logic [9:0]        base_y;
   logic [9:0]        next_probe_x;
   logic [9:0]        next_probe_y;
   logic              x_ok;
   logic              y_ok;

   // Candidates carry an 11th bit so wrap below 0 or above 1023 shows up as bit 10.
   always_comb begin
      start_cand_x = {1'b0, pos_x_q} + {{5{bus.dx[5]}}, bus.dx};
      next_cand_y  = {1'b0, pos_y_q} + {{5{dy_q[5]}}, dy_q};
      x_ok         = !blocked && !cand_x[10];
      y_ok         = !blocked && !cand_y[10];
      next_k       = k + 2'd1;
      base_x       = (state == PY) ? x_res : cand_x[9:0];
      base_y       = (state == PY) ? cand_y[9:0] : pos_y_q;
      next_probe_x = base_x + (next_k[0] ? W_OFF : 10'd0);
      next_probe_y = base_y + (next_k[1] ? H_OFF : 10'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         k             <= 2'd0;
         dx_q          <= '0;
         dy_q          <= '0;
         cand_x        <= '0;
         cand_y        <= '0;
         x_res         <= 10'(X_INIT);
         pos_x_q       <= 10'(X_INIT);
         pos_y_q       <= 10'(Y_INIT);
         probe_x_q     <= '0;
         probe_y_q     <= '0;
         blocked       <= 1'b0;
         hit_wall_n    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         grounded_q    <= 1'b0;
         hit_wall_q    <= 1'b0;
         hit_ceiling_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  dx_q      <= bus.dx;
                  dy_q      <= bus.dy;
                  cand_x    <= start_cand_x;
                  probe_x_q <= start_cand_x[9:0];
                  probe_y_q <= pos_y_q;
                  k         <= 2'd0;
                  blocked   <= 1'b0;
                  busy_q    <= 1'b1;
                  state     <= PX;
               end
            end
            // The hit for the probe presented this cycle is folded in at the edge ending it.
            PX, PY: begin
               blocked <= blocked | bus.probe_hit;
               if (k == 2'd3) begin
                  state <= (state == PX) ? CX : CY;
               end else begin
                  k         <= next_k;
                  probe_x_q <= next_probe_x;
                  probe_y_q <= next_probe_y;
               end
            end
            CX: begin
               x_res      <= x_ok ? cand_x[9:0] : pos_x_q;
               hit_wall_n <= !x_ok && (dx_q != 6'sd0);
               cand_y     <= next_cand_y;
               probe_x_q  <= x_ok ? cand_x[9:0] : pos_x_q;
               probe_y_q  <= next_cand_y[9:0];
               k          <= 2'd0;
               blocked    <= 1'b0;
               state      <= PY;
            end
            CY: begin
               pos_x_q       <= x_res;
               pos_y_q       <= y_ok ? cand_y[9:0] : pos_y_q;
               hit_wall_q    <= hit_wall_n;
               grounded_q    <= !y_ok && (dy_q > 6'sd0);
               hit_ceiling_q <= !y_ok && dy_q[5];
               done_q        <= 1'b1;
               busy_q        <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.probe_x     = probe_x_q;
   assign bus.probe_y     = probe_y_q;
   assign bus.pos_x       = pos_x_q;
   assign bus.pos_y       = pos_y_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.grounded    = grounded_q;
   assign bus.hit_wall    = hit_wall_q;
   assign bus.hit_ceiling = hit_ceiling_q;

endmodule

// File: tb/tb_tile_collider.sv
// Bench for tile_collider: a 20x16 tile map model drives probe_hit, and moves are
// checked against a fixed vector table, corner-case sequences and a random walk.
module tb_tile_collider;

   localparam int X_INIT = 175;
   localparam int Y_INIT = 66;
   localparam int W      = 32;
   localparam int H      = 32;
   localparam int MAP_X0 = 143;
   localparam int MAP_Y0 = 34;
   localparam int TILE   = 32;
   localparam int COLS   = 20;
   localparam int ROWS   = 16;

   typedef struct {
      int dx;
      int dy;
      int ex;
      int ey;
      bit ew;
      bit eg;
      bit ec;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   tile_collider_if bus();

   tile_collider #(.X_INIT(X_INIT), .Y_INIT(Y_INIT), .W(W), .H(H)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   bit   solid [ROWS][COLS];
   bit   force_open = 1'b0;
   int   n_vec      = 0;
   int   n_miss     = 0;
   int   done_count = 0;
   int   pr, pc;
   logic [9:0] plog_x [4];
   logic [9:0] plog_y [4];
   logic busy_at_done;
   logic mid_wall, mid_gnd, mid_ceil;
   vec_t vecs [15];

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.done) done_count++;

   // The map's collision port: combinational from the probe coordinates, off-map is solid.
   always_comb begin
      pc = int'(bus.probe_x) - MAP_X0;
      pr = int'(bus.probe_y) - MAP_Y0;
      if (force_open)
         bus.probe_hit = 1'b0;
      else if (pc < 0 || pc >= COLS * TILE || pr < 0 || pr >= ROWS * TILE)
         bus.probe_hit = 1'b1;
      else
         bus.probe_hit = solid[pr / TILE][pc / TILE];
   end

   function automatic bit map_hit(input int x, input int y);
      if (force_open) return 1'b0;
      if (x < MAP_X0 || x >= MAP_X0 + COLS * TILE || y < MAP_Y0 || y >= MAP_Y0 + ROWS * TILE)
         return 1'b1;
      return solid[(y - MAP_Y0) / TILE][(x - MAP_X0) / TILE];
   endfunction

   function automatic bit box_blocked(input int x, input int y);
      return map_hit(x, y) | map_hit(x + W - 1, y) | map_hit(x, y + H - 1) | map_hit(x + W - 1, y + H - 1);
   endfunction

   task automatic model_move(input int x, input int y, input int vx, input int vy,
                             output int nx, output int ny, output bit w, output bit g, output bit c);
      int  cx, cy;
      bit  bx, by;
      cx = x + vx;
      bx = box_blocked(cx, y) || cx < 0 || cx > 1023;
      nx = bx ? x : cx;
      w  = bx && vx != 0;
      cy = y + vy;
      by = box_blocked(nx, cy) || cy < 0 || cy > 1023;
      ny = by ? y : cy;
      g  = by && vy > 0;
      c  = by && vy < 0;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_vec++;
      if (actual !== expected) begin
         n_miss++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Starts one move and follows it until done, logging the first four probes.
   task automatic applyStimulus(input int vx, input int vy, output int lat);
      @(negedge clk);
      bus.start = 1'b1;
      bus.dx    = 6'(vx);
      bus.dy    = 6'(vy);
      @(posedge clk);
      #1 bus.start = 1'b0;
      lat = -1;
      busy_at_done = 1'bx;
      for (int n = 0; n < 20; n++) begin
         if (n < 4) begin
            plog_x[n] = bus.probe_x;
            plog_y[n] = bus.probe_y;
         end
         if (n == 5) begin
            mid_wall = bus.hit_wall;
            mid_gnd  = bus.grounded;
            mid_ceil = bus.hit_ceiling;
         end
         if (bus.done === 1'b1) begin
            lat = n;
            busy_at_done = bus.busy;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkMove(input string tag, input int lat, input int ex, input int ey,
                            input bit ew, input bit eg, input bit ec);
      checkOutput({tag, " latency"}, lat, 10);
      checkOutput({tag, " busy@done"}, int'(busy_at_done), 0);
      checkOutput({tag, " pos_x"}, int'(bus.pos_x), ex);
      checkOutput({tag, " pos_y"}, int'(bus.pos_y), ey);
      checkOutput({tag, " hit_wall"}, int'(bus.hit_wall), int'(ew));
      checkOutput({tag, " grounded"}, int'(bus.grounded), int'(eg));
      checkOutput({tag, " hit_ceiling"}, int'(bus.hit_ceiling), int'(ec));
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic clearMap();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            solid[r][c] = 1'b0;
   endtask

   task automatic levelMap();
      clearMap();
      solid[1][3] = 1'b1;
      solid[3][1] = 1'b1;
      solid[0][1] = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat, d0, mx, my, nx, ny, vx, vy;
      bit ew, eg, ec;

      vecs[0]  = '{  3,   2, 178, 68, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{ -3,  -2, 175, 66, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{  0,  31, 175, 97, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{  0,   1, 175, 98, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{  0,   4, 175, 98, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{  0,  -3, 175, 95, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{  0, -25, 175, 70, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{  0,  -5, 175, 70, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{ 31,   0, 206, 70, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{  1,   0, 207, 70, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{  1,   0, 207, 70, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{-32,   0, 175, 70, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{-32,   0, 143, 70, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{ -1,   0, 143, 70, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{  0,   0, 143, 70, 1'b0, 1'b0, 1'b0};

      bus.start = 1'b0;
      bus.dx    = '0;
      bus.dy    = '0;

      doReset();
      checkOutput("reset pos_x", int'(bus.pos_x), X_INIT);
      checkOutput("reset pos_y", int'(bus.pos_y), Y_INIT);
      checkOutput("reset probe_x", int'(bus.probe_x), 0);
      checkOutput("reset probe_y", int'(bus.probe_y), 0);
      checkOutput("reset busy", int'(bus.busy), 0);
      checkOutput("reset done", int'(bus.done), 0);
      checkOutput("reset hit_wall", int'(bus.hit_wall), 0);
      checkOutput("reset grounded", int'(bus.grounded), 0);
      checkOutput("reset hit_ceiling", int'(bus.hit_ceiling), 0);

      // Scripted walk through free moves, floor, ceiling, wall and map edge.
      levelMap();
      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].dx, vecs[i].dy, lat);
         checkMove($sformatf("vec%0d", i), lat, vecs[i].ex, vecs[i].ey, vecs[i].ew, vecs[i].eg, vecs[i].ec);
         if (i > 0) begin
            checkOutput($sformatf("vec%0d hold hit_wall", i), int'(mid_wall), int'(vecs[i-1].ew));
            checkOutput($sformatf("vec%0d hold grounded", i), int'(mid_gnd), int'(vecs[i-1].eg));
            checkOutput($sformatf("vec%0d hold hit_ceiling", i), int'(mid_ceil), int'(vecs[i-1].ec));
         end
      end

      // Wall probe order: corners presented in k0..k3 order during PX.
      doReset();
      applyStimulus(31, 0, lat);
      applyStimulus(1, 0, lat);
      checkMove("wall setup", lat, 207, 66, 1'b0, 1'b0, 1'b0);
      applyStimulus(1, 0, lat);
      checkOutput("wall probe_x k0", int'(plog_x[0]), 208);
      checkOutput("wall probe_x k1", int'(plog_x[1]), 239);
      checkOutput("wall probe_x k2", int'(plog_x[2]), 208);
      checkOutput("wall probe_x k3", int'(plog_x[3]), 239);
      checkOutput("wall probe_y k0", int'(plog_y[0]), 66);
      checkOutput("wall probe_y k3", int'(plog_y[3]), 97);
      checkMove("wall", lat, 207, 66, 1'b1, 1'b0, 1'b0);

      // A start pulsed while busy must be ignored.
      doReset();
      clearMap();
      d0 = done_count;
      @(negedge clk);
      bus.start = 1'b1;
      bus.dx    = 6'(2);
      bus.dy    = 6'(0);
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      bus.dx    = 6'(10);
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      checkOutput("busy-start done count", done_count - d0, 1);
      checkOutput("busy-start pos_x", int'(bus.pos_x), 177);
      checkOutput("busy-start busy", int'(bus.busy), 0);

      // Asynchronous reset in the middle of a move.
      d0 = done_count;
      @(negedge clk);
      bus.start = 1'b1;
      bus.dx    = 6'(5);
      bus.dy    = 6'(3);
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midreset busy", int'(bus.busy), 0);
      checkOutput("midreset pos_x", int'(bus.pos_x), X_INIT);
      checkOutput("midreset pos_y", int'(bus.pos_y), Y_INIT);
      checkOutput("midreset done", int'(bus.done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      checkOutput("midreset done count", done_count - d0, 0);
      checkOutput("midreset pos_x after", int'(bus.pos_x), X_INIT);

      // Range check alone: map always open, walk off the 0 edge on both axes.
      doReset();
      force_open = 1'b1;
      mx = X_INIT;
      my = Y_INIT;
      for (int i = 0; i < 9; i++) begin
         vx = (i < 5) ? -32 : ((i == 5) ? -16 : 0);
         vy = (i == 6 || i == 7) ? -32 : ((i == 8) ? -3 : 0);
         model_move(mx, my, vx, vy, nx, ny, ew, eg, ec);
         applyStimulus(vx, vy, lat);
         checkMove($sformatf("range%0d", i), lat, nx, ny, ew, eg, ec);
         mx = nx;
         my = ny;
         if (i == 5) begin
            checkOutput("range left pos_x", int'(bus.pos_x), 15);
            checkOutput("range left hit_wall", int'(bus.hit_wall), 1);
         end
      end
      checkOutput("range top pos_y", int'(bus.pos_y), 2);
      checkOutput("range top hit_ceiling", int'(bus.hit_ceiling), 1);
      force_open = 1'b0;

      // Random walk on a random map against the reference model.
      doReset();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            solid[r][c] = ($urandom_range(0, 99) < 15) && !(r < 4 && c < 4);
      mx = X_INIT;
      my = Y_INIT;
      for (int i = 0; i < 40; i++) begin
         vx = int'($urandom_range(0, 63)) - 32;
         vy = int'($urandom_range(0, 63)) - 32;
         if (i % 7 == 3) vx = 0;
         model_move(mx, my, vx, vy, nx, ny, ew, eg, ec);
         applyStimulus(vx, vy, lat);
         checkMove($sformatf("rand%0d", i), lat, nx, ny, ew, eg, ec);
         mx = nx;
         my = ny;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
